// File: rtl/fxp_disp_pkg.sv
// Shared definitions for the fixed-point to BCD display converter.
//   state_t         : converter FSM states
//   bcd_digit_t     : one packed BCD digit
//   BCD_NINE        : largest decimal digit; used to saturate on overflow
//   BCD_ADD3_THRESH : double-dabble correction threshold
//   calc_width()    : input word width from the integer/fraction bit counts
package fxp_disp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONV_I = 3'd1,
        ST_CONV_F = 3'd2,
        ST_FIN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE        = 4'd9;
    localparam bcd_digit_t BCD_ADD3_THRESH = 4'd5;

    // Sign bit + integer magnitude bits + fraction bits.
    function automatic int calc_width(input int int_bits, input int frac_bits);
        return 1 + int_bits + frac_bits;
    endfunction

endpackage

// File: rtl/fxp_to_bcd_seq_if.sv
// Handshake/data bundle for fxp_to_bcd_seq.
//   in_valid/in_ready/in_data        : fixed-point input word handshake
//   out_valid/out_ready              : result handshake
//   out_neg, out_int_bcd, out_frac_bcd, out_blank, out_ovf : display result
//   busy                             : conversion in progress
// Modport slave is the converter side, master is the producer/consumer side.
interface fxp_to_bcd_seq_if
    import fxp_disp_pkg::*;
#(
    parameter int INT_BITS    = 9,
    parameter int FRAC_BITS   = 6,
    parameter int INT_DIGITS  = 3,
    parameter int FRAC_DIGITS = 2
);
    localparam int W = calc_width(INT_BITS, FRAC_BITS);

    logic                       in_valid;
    logic                       in_ready;
    logic [W-1:0]               in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_neg;
    logic [4*INT_DIGITS-1:0]    out_int_bcd;
    logic [4*FRAC_DIGITS-1:0]   out_frac_bcd;
    logic [INT_DIGITS-1:0]      out_blank;
    logic                       out_ovf;
    logic                       busy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_neg, out_int_bcd, out_frac_bcd,
               out_blank, out_ovf, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_neg, out_int_bcd, out_frac_bcd,
               out_blank, out_ovf, busy
    );

endinterface

// File: rtl/bcd_inc.sv
// Combinational N-digit decimal increment.
//   d         : packed BCD input, digit 0 in the low nibble
//   q         : d + 1 with decimal carry between digits
//   carry_out : set when every digit of d is 9 (result wrapped to all zeros)
// Carry into each digit is derived directly from the "all lower digits are 9"
// condition rather than a rippled chain, which keeps the netlist acyclic.
module bcd_inc
    import fxp_disp_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [4*N-1:0] d,
    output logic [4*N-1:0] q,
    output logic           carry_out
);
    logic [N-1:0] nine;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dig
            bcd_digit_t din;
            logic       cin;
            assign din      = d[4*gi +: 4];
            assign nine[gi] = (din == BCD_NINE);
            if (gi == 0) begin : g_lsd
                assign cin = 1'b1;
            end else begin : g_upper
                assign cin = &nine[gi-1:0];
            end
            assign q[4*gi +: 4] = !cin ? din : (nine[gi] ? 4'd0 : din + 4'd1);
        end
    endgenerate

    assign carry_out = &nine;

endmodule

// File: rtl/fxp_to_bcd_seq.sv
// Sequential fixed-point to decimal-digit converter for the display path.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : slave side of fxp_to_bcd_seq_if (input handshake, result
//                handshake, BCD digits, sign, blank mask, overflow, busy)
// Integer part: double-dabble, one bit per cycle, into an accumulator one
// nibble wider than the display so overflow is visible. Fraction part: one
// x10 step per produced digit. FIN optionally rounds and saturates.
module fxp_to_bcd_seq
    import fxp_disp_pkg::*;
#(
    parameter int INT_BITS    = 9,
    parameter int FRAC_BITS   = 6,
    parameter int INT_DIGITS  = 3,
    parameter int FRAC_DIGITS = 2,
    parameter int SIGNED_MODE = 0,
    parameter int ROUND       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    fxp_to_bcd_seq_if.slave   bus
);
    localparam int W     = calc_width(INT_BITS, FRAC_BITS);
    localparam int ACC_N = INT_DIGITS + 1;
    localparam int ACC_W = 4 * ACC_N;
    localparam int IB_W  = 4 * INT_DIGITS;
    localparam int FB_W  = 4 * FRAC_DIGITS;
    localparam int VEC_W = ACC_W + FB_W;
    localparam int CNT_W = $clog2(INT_BITS + FRAC_DIGITS + 2);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sign_q, sign_d;
    logic [INT_BITS:0]      int_q, int_d;
    logic [FRAC_BITS-1:0]   frac_q, frac_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [FB_W-1:0]        fbcd_q, fbcd_d;
    logic                   sticky_q, sticky_d;
    logic [IB_W-1:0]        out_int_q, out_int_d;
    logic [FB_W-1:0]        out_frac_q, out_frac_d;
    logic [INT_DIGITS-1:0]  out_blank_q, out_blank_d;
    logic                   out_ovf_q, out_ovf_d;
    logic                   out_neg_q, out_neg_d;

    // Magnitude of the incoming word as {integer(INT_BITS+1), fraction}.
    // In two's complement the most negative word negates to 2^(W-1), which
    // lands exactly on 2^INT_BITS in the widened integer field.
    logic [W-1:0] mag;
    always_comb begin
        mag = {1'b0, bus.in_data[W-2:0]};
        if (SIGNED_MODE != 0) begin
            mag = bus.in_data[W-1] ? (~bus.in_data + W'(1)) : bus.in_data;
        end
    end

    // Double-dabble correction of every accumulator nibble before the shift.
    logic [ACC_W-1:0] acc_adj;
    genvar gi;
    generate
        for (gi = 0; gi < ACC_N; gi++) begin : g_add3
            bcd_digit_t nib;
            assign nib = acc_q[4*gi +: 4];
            assign acc_adj[4*gi +: 4] = (nib >= BCD_ADD3_THRESH) ? nib + 4'd3 : nib;
        end
    endgenerate

    // frac * 10 = frac*8 + frac*2; bits above FRAC_BITS are the next digit.
    logic [FRAC_BITS+3:0] frac_x10;
    assign frac_x10 = {1'b0, frac_q, 3'b000} + {3'b000, frac_q, 1'b0};

    // Finalisation: optional round-half-up across the whole digit vector.
    logic [VEC_W-1:0] vec_raw, vec_inc, vec_fin;
    logic             inc_carry, round_up, fin_ovf, fin_nz;
    logic [IB_W-1:0]  fin_int;
    logic [FB_W-1:0]  fin_frac;
    logic [INT_DIGITS-1:0] hi_zero, fin_blank;

    assign vec_raw = {acc_q, fbcd_q};

    bcd_inc #(.N(ACC_N + FRAC_DIGITS)) u_bcd_inc (
        .d         (vec_raw),
        .q         (vec_inc),
        .carry_out (inc_carry)
    );

    assign round_up = (ROUND != 0) && frac_q[FRAC_BITS-1];
    assign vec_fin  = round_up ? vec_inc : vec_raw;
    // The sticky bit catches magnitudes whose leading digit was shifted out
    // past the guard nibble (e.g. 100 with a one-digit display).
    assign fin_ovf  = (vec_fin[VEC_W-1 -: 4] != 4'd0) | sticky_q | (round_up & inc_carry);
    assign fin_int  = fin_ovf ? {INT_DIGITS{BCD_NINE}}  : vec_fin[FB_W +: IB_W];
    assign fin_frac = fin_ovf ? {FRAC_DIGITS{BCD_NINE}} : vec_fin[FB_W-1:0];
    assign fin_nz   = (|fin_int) | (|fin_frac);

    // A digit is blanked when it and every more significant digit are zero;
    // the units digit always shows. Saturated 9s are never blanked.
    generate
        for (gi = 0; gi < INT_DIGITS; gi++) begin : g_blank
            assign hi_zero[gi] = (fin_int[IB_W-1:4*gi] == '0);
        end
    endgenerate
    assign fin_blank = hi_zero & ~INT_DIGITS'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        int_d       = int_q;
        frac_d      = frac_q;
        acc_d       = acc_q;
        fbcd_d      = fbcd_q;
        sticky_d    = sticky_q;
        out_int_d   = out_int_q;
        out_frac_d  = out_frac_q;
        out_blank_d = out_blank_q;
        out_ovf_d   = out_ovf_q;
        out_neg_d   = out_neg_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sign_d   = bus.in_data[W-1];
                    int_d    = mag[W-1:FRAC_BITS];
                    frac_d   = mag[FRAC_BITS-1:0];
                    acc_d    = '0;
                    fbcd_d   = '0;
                    sticky_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_CONV_I;
                end
            end
            ST_CONV_I: begin
                acc_d    = (acc_adj << 1) | ACC_W'(int_q[INT_BITS]);
                sticky_d = sticky_q | acc_adj[ACC_W-1];
                int_d    = {int_q[INT_BITS-1:0], 1'b0};
                if (cnt_q == CNT_W'(INT_BITS)) begin
                    cnt_d   = '0;
                    state_d = ST_CONV_F;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CONV_F: begin
                // Tenths enter first and end up in the top nibble.
                fbcd_d = (fbcd_q << 4) | FB_W'(frac_x10[FRAC_BITS+3:FRAC_BITS]);
                frac_d = frac_x10[FRAC_BITS-1:0];
                if (cnt_q == CNT_W'(FRAC_DIGITS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FIN: begin
                out_int_d   = fin_int;
                out_frac_d  = fin_frac;
                out_blank_d = fin_blank;
                out_ovf_d   = fin_ovf;
                out_neg_d   = sign_q & (fin_nz | fin_ovf);
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            int_q       <= '0;
            frac_q      <= '0;
            acc_q       <= '0;
            fbcd_q      <= '0;
            sticky_q    <= 1'b0;
            out_int_q   <= '0;
            out_frac_q  <= '0;
            out_blank_q <= '0;
            out_ovf_q   <= 1'b0;
            out_neg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            int_q       <= int_d;
            frac_q      <= frac_d;
            acc_q       <= acc_d;
            fbcd_q      <= fbcd_d;
            sticky_q    <= sticky_d;
            out_int_q   <= out_int_d;
            out_frac_q  <= out_frac_d;
            out_blank_q <= out_blank_d;
            out_ovf_q   <= out_ovf_d;
            out_neg_q   <= out_neg_d;
        end
    end

    assign bus.in_ready     = (state_q == ST_IDLE);
    assign bus.out_valid    = (state_q == ST_DONE);
    assign bus.busy         = (state_q == ST_CONV_I) || (state_q == ST_CONV_F) || (state_q == ST_FIN);
    assign bus.out_int_bcd  = out_int_q;
    assign bus.out_frac_bcd = out_frac_q;
    assign bus.out_blank    = out_blank_q;
    assign bus.out_ovf      = out_ovf_q;
    assign bus.out_neg      = out_neg_q;

endmodule

// File: doc/fxp_to_bcd_seq.md
Name: fxp_to_bcd_seq

Overview:
Sequential, parametrised fixed-point to decimal-digit converter for the calculator display path. It is the next generation of the combinational binary-to-7-segment splitter. It accepts one fixed-point result per valid/ready handshake and produces packed BCD integer and fraction digits, a sign flag, a leading-zero blank mask and an overflow flag. The integer part uses iterative double-dabble and the fraction part uses repeated ×10. It sits between the ALU result register and the 7-segment encoder.

Parameters:
INT_BITS, 9, integer magnitude bits; input width W = 1+INT_BITS+FRAC_BITS.
FRAC_BITS, 6, fractional bits.
INT_DIGITS, 3, decimal integer digits produced.
FRAC_DIGITS, 2, decimal fraction digits produced.
SIGNED_MODE, 0, input format: 0 = sign-magnitude (MSB is sign), 1 = two's complement.
ROUND, 0, 0 = truncate the fraction, 1 = round half up at the last fraction digit.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, synchronous, active-low.
in_valid  in  1  input word valid.
in_ready  out  1  block can accept a word.
in_data  in  W  fixed-point input.
out_valid  out  1  result valid; held until accepted.
out_ready  in  1  consumer accepts the result.
out_neg  out  1  display minus sign.
out_int_bcd  out  4*INT_DIGITS  integer BCD digits, most significant digit in the top nibble.
out_frac_bcd  out  4*FRAC_DIGITS  fraction BCD digits, tenths in the top nibble.
out_blank  out  INT_DIGITS  per integer digit, 1 = leading zero to blank.
out_ovf  out  1  result not representable in INT_DIGITS digits.
busy  out  1  conversion in progress.

Behaviour:
- Reset (clk edge with rst_n=0): state IDLE. All outputs are 0 except in_ready=1. Reset overrides everything, including mid-conversion; no partial result is emitted.
- FSM states: IDLE → CONV_I → CONV_F → FIN → DONE → IDLE.
- in_ready=1 only in IDLE.
- Accept when in_valid & in_ready. On the accepting edge:
  - The sign is captured.
  - The magnitude is computed into an (INT_BITS+1)-bit integer register and a FRAC_BITS-bit fraction register. SM mode: magnitude = lower W-1 bits. 2C mode: |in_data|, so the most negative input gives 2^INT_BITS exactly.
  - The BCD accumulators are cleared and the state goes to CONV_I.
- CONV_I: exactly INT_BITS+1 cycles. Each cycle adds 3 to every BCD nibble ≥5, then shifts left, bringing in the integer MSB. The BCD accumulator is INT_DIGITS+1 nibbles wide so overflow can be detected.
- CONV_F: exactly FRAC_DIGITS cycles. Each cycle: frac×10; the bits above FRAC_BITS give the next digit; the low FRAC_BITS bits are kept as the remainder.
- FIN: 1 cycle.
  - If ROUND=1 and remainder ≥ 2^(FRAC_BITS-1), the whole BCD vector is incremented by 1 with decimal carry, fraction digits into integer digits.
  - out_ovf=1 if the top guard nibble ≠ 0. On overflow, all output digits are forced to 9 and out_blank is forced to 0.
- out_valid rises after FIN. Latency from the accepting edge to out_valid=1 is INT_BITS+FRAC_DIGITS+3 edges (14 with defaults). The latency is fixed and independent of data.
- DONE:
  - Outputs are stable while out_valid & !out_ready.
  - On out_valid & out_ready: out_valid drops and the state goes to IDLE.
  - The next accept is possible on the following edge. Results never overlap.
- out_neg = captured sign & (any output digit ≠ 0 or out_ovf). This means -0 and negative values that truncate to 0.00 display unsigned.
- out_blank[i] = 1 if integer digit i and all higher integer digits are 0. The units digit is never blanked.
- busy = state ∈ {CONV_I, CONV_F, FIN}.
- in_valid while busy or in DONE is ignored (in_ready=0); the word is not captured.

Decomposition:
- Package fxp_disp_pkg holds:
  - the state enum;
  - the bcd_digit_t 4-bit type;
  - constants BCD_NINE and BCD_ADD3_THRESH=5;
  - a function computing W from the parameters.
- One sub-module, bcd_inc: a combinational N-nibble decimal increment with carry-out, used in FIN.

Test Plan:
- Defaults, in_data=0x0CA8 (50.625) → after 14 cycles: int=0x050, frac=0x62, blank=3'b100, neg=0, ovf=0.
- ROUND=1, in_data=0x0CA8 → frac=0x63, int=0x050. Same input with bit15 set (0x8CA8), ROUND=0 → neg=1, digits 050.62.
- SM, in_data=0x8000 (-0) → neg=0, int=0x000, frac=0x00, blank=3'b110. SIGNED_MODE=1, in_data=0x8000 → neg=1, int=0x512, frac=0x00; in_data=0xFFC0 → neg=1, 001.00.
- INT_DIGITS=1, FRAC_DIGITS=1, ROUND=1, in_data=0x027E (9.96875) → rounding carries to 10.0 → ovf=1, digits 9.9, blank=0.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles → outputs stable and in_ready=0; pulse in_valid with a new word → ignored.
  - Raise out_ready → out_valid drops, in_ready=1 next cycle.
  - Assert rst_n=0 during CONV_I → next edge: IDLE, all outputs 0, in_ready=1.
